// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game slice: FSM state codes, timer speed codes,
// parameter defaults and the round-to-speed mapping.
package simon_pkg;

    localparam int unsigned DEF_MAX_ROUND          = 31;
    localparam int unsigned DEF_ROUNDS_PER_SPEEDUP = 4;
    localparam int unsigned DEF_TIMEOUT_PULSES     = 8;

    localparam int unsigned ROUND_W = 5;
    localparam int unsigned TMO_W   = 4;
    localparam int unsigned SPEED_W = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SPEED = 3'd3;
    localparam logic [2:0] S_FLASH = 3'd4;
    localparam logic [2:0] S_PLAY  = 3'd5;
    localparam logic [2:0] S_WIN   = 3'd6;
    localparam logic [2:0] S_LOSE  = 3'd7;

    // Typed view of the state codes for waveform viewers and other blocks.
    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_SEED  = S_SEED,
        ST_ADD   = S_ADD,
        ST_SPEED = S_SPEED,
        ST_FLASH = S_FLASH,
        ST_PLAY  = S_PLAY,
        ST_WIN   = S_WIN,
        ST_LOSE  = S_LOSE
    } state_e;

    typedef enum logic [2:0] {
        SPEED_1HZ  = 3'd0,
        SPEED_2HZ  = 3'd1,
        SPEED_4HZ  = 3'd2,
        SPEED_8HZ  = 3'd3,
        SPEED_16HZ = 3'd4
    } speed_e;

    // One speed step per ROUNDS_PER_SPEEDUP completed rounds, saturating at 16 Hz.
    function automatic logic [2:0] speed_for_round(input logic [4:0] round,
                                                   input int unsigned per);
        int unsigned steps;
        if (per == 32'd0) begin
            steps = 32'd4;
        end else begin
            steps = 32'(round) / per;
        end
        if (steps >= 32'd4) begin
            return SPEED_16HZ;
        end else begin
            return 3'(steps);
        end
    endfunction

endpackage

// File: rtl/game_control.sv
// Simon game sequencer: grows the colour sequence, flashes it back, then checks the
// player's entries with a per-entry idle timeout.
module game_control
    import simon_pkg::*;
#(
    parameter int unsigned MAX_ROUND          = DEF_MAX_ROUND,
    parameter int unsigned ROUNDS_PER_SPEEDUP = DEF_ROUNDS_PER_SPEEDUP,
    parameter int unsigned TIMEOUT_PULSES     = DEF_TIMEOUT_PULSES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               pulse,
    input  logic               empty,
    input  logic               result,
    output logic               rst_seedgen,
    output logic               start,
    output logic               load_colour,
    output logic               load_speed,
    output logic               pop,
    output logic               flash_colour,
    output logic               player_turn,
    output logic               game_over,
    output logic               win,
    output logic [ROUND_W-1:0] check_round,
    output logic [SPEED_W-1:0] speed
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUND);
    localparam logic [TMO_W-1:0]   TMO_LIMIT  = TMO_W'(TIMEOUT_PULSES);

    logic [2:0]         state_q, state_d;
    logic [ROUND_W-1:0] r_q, r_d;
    logic [ROUND_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [TMO_W-1:0]   tmo_inc_s;

    assign tmo_inc_s = tmo_q + 4'd1;

    // Next-state and datapath update; a player entry always outranks a coincident pulse.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        speed_d = speed_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_SEED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEED: begin
                r_d     = 5'd0;
                state_d = S_ADD;
            end
            S_ADD: begin
                // Speed is latched on the way into SPEED so it is valid alongside load_speed.
                speed_d = speed_for_round(r_q, ROUNDS_PER_SPEEDUP);
                state_d = S_SPEED;
            end
            S_SPEED: begin
                idx_d   = 5'd0;
                state_d = S_FLASH;
            end
            S_FLASH: begin
                if (!pulse) begin
                    state_d = S_FLASH;
                end else if (idx_q == r_q) begin
                    idx_d   = 5'd0;
                    tmo_d   = 4'd0;
                    state_d = S_PLAY;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_PLAY: begin
                if (!empty) begin
                    if (!result) begin
                        state_d = S_LOSE;
                    end else if (idx_q < r_q) begin
                        idx_d = idx_q + 5'd1;
                        tmo_d = 4'd0;
                    end else if (r_q == LAST_ROUND) begin
                        state_d = S_WIN;
                    end else begin
                        r_d     = r_q + 5'd1;
                        state_d = S_ADD;
                    end
                end else if (pulse) begin
                    tmo_d = tmo_inc_s;
                    if (tmo_inc_s == TMO_LIMIT) begin
                        state_d = S_LOSE;
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_WIN, S_LOSE: begin
                if (go) begin
                    state_d = S_SEED;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            r_q     <= 5'd0;
            idx_q   <= 5'd0;
            tmo_q   <= 4'd0;
            speed_q <= 3'd0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            speed_q <= speed_d;
        end
    end

    // Strobe and level decode from the registered state; pop follows a pending entry.
    always_comb begin
        rst_seedgen  = 1'b0;
        start        = 1'b0;
        load_colour  = 1'b0;
        load_speed   = 1'b0;
        pop          = 1'b0;
        flash_colour = 1'b0;
        player_turn  = 1'b0;
        game_over    = 1'b0;
        win          = 1'b0;
        check_round  = 5'd0;
        case (state_q)
            S_SEED: begin
                rst_seedgen = 1'b1;
            end
            S_ADD: begin
                start       = 1'b1;
                load_colour = 1'b1;
            end
            S_SPEED: begin
                load_speed = 1'b1;
            end
            S_FLASH: begin
                flash_colour = 1'b1;
                check_round  = idx_q;
            end
            S_PLAY: begin
                player_turn = 1'b1;
                check_round = idx_q;
                pop         = ~empty;
            end
            S_WIN: begin
                win         = 1'b1;
                check_round = idx_q;
            end
            S_LOSE: begin
                game_over   = 1'b1;
                check_round = idx_q;
            end
            default: begin
                check_round = 5'd0;
            end
        endcase
    end

    assign speed = speed_q;

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control: vector table, directed corner sequences and
// randomized stimulus against a behavioural model; a second instance uses MAX_ROUND=3.
module tb_game_control;

    localparam logic [8:0] F_SEED  = 9'b1_0000_0000;
    localparam logic [8:0] F_ADD   = 9'b0_1100_0000;
    localparam logic [8:0] F_SPEED = 9'b0_0010_0000;
    localparam logic [8:0] F_POP   = 9'b0_0001_0000;
    localparam logic [8:0] F_FLASH = 9'b0_0000_1000;
    localparam logic [8:0] F_PLAY  = 9'b0_0000_0100;
    localparam logic [8:0] F_LOSE  = 9'b0_0000_0010;
    localparam logic [8:0] F_WIN   = 9'b0_0000_0001;

    typedef enum int {M_IDLE, M_SEED, M_ADD, M_SPEED, M_FLASH, M_PLAY, M_WIN, M_LOSE} mph_e;
    typedef struct {
        mph_e ph;
        int   r;
        int   idx;
        int   tmo;
        int   spd;
    } model_t;

    typedef struct {
        logic        go;
        logic        pulse;
        logic        empty;
        logic        result;
        logic [16:0] exp;
    } vec_t;

    logic clk;
    logic a_reset, a_go, a_pulse, a_empty, a_result;
    logic b_reset, b_go, b_pulse, b_empty, b_result;
    logic a_rs, a_st, a_lc, a_ls, a_pop, a_fc, a_pt, a_go_o, a_win;
    logic b_rs, b_st, b_lc, b_ls, b_pop, b_fc, b_pt, b_go_o, b_win;
    logic [4:0] a_cr, b_cr;
    logic [2:0] a_sp, b_sp;
    logic [16:0] out_a, out_b, last_a, last_b;

    int n_checks = 0;
    int n_fail   = 0;
    model_t ma, mb;
    vec_t vecs[18];

    game_control dut_a (
        .clk(clk), .reset(a_reset), .go(a_go), .pulse(a_pulse), .empty(a_empty),
        .result(a_result), .rst_seedgen(a_rs), .start(a_st), .load_colour(a_lc),
        .load_speed(a_ls), .pop(a_pop), .flash_colour(a_fc), .player_turn(a_pt),
        .game_over(a_go_o), .win(a_win), .check_round(a_cr), .speed(a_sp)
    );

    game_control #(.MAX_ROUND(3)) dut_b (
        .clk(clk), .reset(b_reset), .go(b_go), .pulse(b_pulse), .empty(b_empty),
        .result(b_result), .rst_seedgen(b_rs), .start(b_st), .load_colour(b_lc),
        .load_speed(b_ls), .pop(b_pop), .flash_colour(b_fc), .player_turn(b_pt),
        .game_over(b_go_o), .win(b_win), .check_round(b_cr), .speed(b_sp)
    );

    assign out_a = {a_rs, a_st, a_lc, a_ls, a_pop, a_fc, a_pt, a_go_o, a_win, a_cr, a_sp};
    assign out_b = {b_rs, b_st, b_lc, b_ls, b_pop, b_fc, b_pt, b_go_o, b_win, b_cr, b_sp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] mk(input logic [8:0] f, input int cr, input int sp);
        return {f, 5'(cr), 3'(sp)};
    endfunction

    function automatic vec_t v(input logic g, input logic p, input logic e, input logic res,
                               input logic [16:0] exp);
        vec_t t;
        t.go = g; t.pulse = p; t.empty = e; t.result = res; t.exp = exp;
        return t;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.ph = M_IDLE; m.r = 0; m.idx = 0; m.tmo = 0; m.spd = 0;
        return m;
    endfunction

    // Game rules as one step per clock.
    function automatic model_t model_step(input model_t m, input logic rs, input logic g,
                                          input logic p, input logic e, input logic res,
                                          input int maxr);
        model_t n;
        n = m;
        if (rs) return model_reset();
        case (m.ph)
            M_IDLE:  if (g) n.ph = M_SEED;
            M_SEED:  begin n.r = 0; n.ph = M_ADD; end
            M_ADD:   begin n.spd = (m.r / 4 > 4) ? 4 : m.r / 4; n.ph = M_SPEED; end
            M_SPEED: begin n.idx = 0; n.ph = M_FLASH; end
            M_FLASH: if (p) begin
                if (m.idx == m.r) begin n.ph = M_PLAY; n.idx = 0; n.tmo = 0; end
                else n.idx = m.idx + 1;
            end
            M_PLAY: begin
                if (!e) begin
                    if (!res) n.ph = M_LOSE;
                    else if (m.idx < m.r) begin n.idx = m.idx + 1; n.tmo = 0; end
                    else if (m.r == maxr) n.ph = M_WIN;
                    else begin n.r = m.r + 1; n.ph = M_ADD; end
                end else if (p) begin
                    n.tmo = m.tmo + 1;
                    if (n.tmo == 8) n.ph = M_LOSE;
                end
            end
            M_WIN, M_LOSE: if (g) n.ph = M_SEED;
            default: n = m;
        endcase
        return n;
    endfunction

    function automatic logic [16:0] model_out(input model_t m, input logic e);
        logic [8:0] f;
        int cr;
        f = 9'd0;
        cr = 0;
        case (m.ph)
            M_SEED:  f = F_SEED;
            M_ADD:   f = F_ADD;
            M_SPEED: f = F_SPEED;
            M_FLASH: begin f = F_FLASH; cr = m.idx; end
            M_PLAY:  begin f = e ? F_PLAY : (F_PLAY | F_POP); cr = m.idx; end
            M_WIN:   begin f = F_WIN; cr = m.idx; end
            M_LOSE:  begin f = F_LOSE; cr = m.idx; end
            default: f = 9'd0;
        endcase
        return mk(f, cr, m.spd);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive the selected DUT, park the other, check both against the model.
    task automatic cyc(input bit sel_b, input logic rs, input logic g, input logic p,
                       input logic e, input logic res);
        if (!sel_b) begin
            a_reset = rs; a_go = g; a_pulse = p; a_empty = e; a_result = res;
            b_reset = 1'b0; b_go = 1'b0; b_pulse = 1'b0; b_empty = 1'b1; b_result = 1'b0;
        end else begin
            b_reset = rs; b_go = g; b_pulse = p; b_empty = e; b_result = res;
            a_reset = 1'b0; a_go = 1'b0; a_pulse = 1'b0; a_empty = 1'b1; a_result = 1'b0;
        end
        #1;
        chk("model_a", 32'(out_a), 32'(model_out(ma, a_empty)));
        chk("model_b", 32'(out_b), 32'(model_out(mb, b_empty)));
        last_a = out_a;
        last_b = out_b;
        @(posedge clk);
        ma = model_step(ma, a_reset, a_go, a_pulse, a_empty, a_result, 31);
        mb = model_step(mb, b_reset, b_go, b_pulse, b_empty, b_result, 3);
        @(negedge clk);
    endtask

    task automatic idle(input bit sel_b);
        cyc(sel_b, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // From IDLE/WIN/LOSE: go, then SEED, ADD, SPEED, one pulse in FLASH -> PLAY at r=0.
    task automatic restart_to_play(input bit sel_b);
        cyc(sel_b, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(sel_b);
        cyc(sel_b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // From ADD: play round r fully correct.
    task automatic play_round(input bit sel_b, input int r);
        idle(sel_b);
        chk("add_strobe", sel_b ? 32'(last_b[16:8]) : 32'(last_a[16:8]), 32'(F_ADD));
        idle(sel_b);
        if (!sel_b && r >= 16) chk("speed_sat", 32'(last_a[2:0]), 32'd4);
        if (!sel_b && r == 4) chk("speed_r4", 32'(last_a[2:0]), 32'd1);
        if (!sel_b && r < 4) chk("speed_low", 32'(last_a[2:0]), 32'd0);
        for (int k = 0; k <= r; k++) begin
            cyc(sel_b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("flash_cr", sel_b ? 32'(last_b[7:3]) : 32'(last_a[7:3]), 32'(k));
        end
        for (int k = 0; k <= r; k++) begin
            cyc(sel_b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("entry_pop", sel_b ? 32'({last_b[16:8], last_b[7:3]}) : 32'({last_a[16:8], last_a[7:3]}),
                32'({F_PLAY | F_POP, 5'(k)}));
        end
    endtask

    initial begin
        a_reset = 1'b1; a_go = 1'b0; a_pulse = 1'b0; a_empty = 1'b1; a_result = 1'b0;
        b_reset = 1'b1; b_go = 1'b0; b_pulse = 1'b0; b_empty = 1'b1; b_result = 1'b0;
        last_a = 17'd0;
        last_b = 17'd0;
        @(posedge clk);
        ma = model_reset();
        mb = model_reset();
        @(negedge clk);

        vecs[0]  = v(1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
        vecs[1]  = v(1'b1, 1'b0, 1'b1, 1'b0, 17'd0);
        vecs[2]  = v(1'b0, 1'b0, 1'b1, 1'b0, mk(F_SEED, 0, 0));
        vecs[3]  = v(1'b0, 1'b0, 1'b1, 1'b0, mk(F_ADD, 0, 0));
        vecs[4]  = v(1'b0, 1'b0, 1'b1, 1'b0, mk(F_SPEED, 0, 0));
        vecs[5]  = v(1'b0, 1'b1, 1'b1, 1'b0, mk(F_FLASH, 0, 0));
        vecs[6]  = v(1'b0, 1'b0, 1'b0, 1'b1, mk(F_PLAY | F_POP, 0, 0));
        vecs[7]  = v(1'b1, 1'b0, 1'b1, 1'b0, mk(F_ADD, 0, 0));
        vecs[8]  = v(1'b0, 1'b0, 1'b1, 1'b0, mk(F_SPEED, 0, 0));
        vecs[9]  = v(1'b0, 1'b0, 1'b1, 1'b0, mk(F_FLASH, 0, 0));
        vecs[10] = v(1'b0, 1'b1, 1'b1, 1'b0, mk(F_FLASH, 0, 0));
        vecs[11] = v(1'b0, 1'b1, 1'b1, 1'b0, mk(F_FLASH, 1, 0));
        vecs[12] = v(1'b0, 1'b0, 1'b0, 1'b1, mk(F_PLAY | F_POP, 0, 0));
        vecs[13] = v(1'b0, 1'b1, 1'b1, 1'b0, mk(F_PLAY, 1, 0));
        vecs[14] = v(1'b0, 1'b0, 1'b0, 1'b0, mk(F_PLAY | F_POP, 1, 0));
        vecs[15] = v(1'b0, 1'b1, 1'b1, 1'b0, mk(F_LOSE, 1, 0));
        vecs[16] = v(1'b1, 1'b0, 1'b1, 1'b0, mk(F_LOSE, 1, 0));
        vecs[17] = v(1'b0, 1'b0, 1'b1, 1'b0, mk(F_SEED, 0, 0));
        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, 1'b0, vecs[i].go, vecs[i].pulse, vecs[i].empty, vecs[i].result);
            chk($sformatf("vec%0d", i), 32'(last_a), 32'(vecs[i].exp));
        end

        // Full game on the default instance: rounds 0..31 all correct, then WIN.
        for (int r = 0; r <= 31; r++) play_round(1'b0, r);
        idle(1'b0);
        chk("win_a", 32'(last_a), 32'(mk(F_WIN, 31, 4)));

        // Timeout: 7 idle pulses keep PLAY, the 8th loses.
        restart_to_play(1'b0);
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("tmo7_play", 32'(last_a[16:8]), 32'(F_PLAY));
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("tmo8_lose", 32'(last_a[16:8]), 32'(F_LOSE));

        // Entry coincident with the 8th pulse is processed instead of timing out.
        restart_to_play(1'b0);
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("tmo8_entry_pop", 32'(last_a[16:8]), 32'(F_PLAY | F_POP));
        idle(1'b0);
        chk("tmo8_entry_add", 32'(last_a[16:8]), 32'(F_ADD));

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 9) != 0));
        end

        // Small instance: win after round 3, then reset in the middle of FLASH.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        for (int r = 0; r <= 3; r++) play_round(1'b1, r);
        idle(1'b1);
        chk("win_b", 32'(last_b), 32'(mk(F_WIN, 3, 0)));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        idle(1'b1);
        chk("flash_b", 32'(last_b), 32'(mk(F_FLASH, 0, 0)));
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("reset_mid_flash", 32'(last_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_control.md
GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 SHALL have parameter MAX_ROUND, default 31, index of final round (sequence length MAX_ROUND+1).
REQ-002 SHALL have parameter ROUNDS_PER_SPEEDUP, default 4, completed rounds per speed step.
REQ-003 SHALL have parameter TIMEOUT_PULSES, default 8, idle timer pulses allowed per player entry.
REQ-004 SHALL have ports (clock and reset first): clk in 1, clock; reset in 1, reset, synchronous, active-high.
REQ-005 SHALL have input go, 1 bit, start/restart request (level, sampled per cycle).
REQ-006 SHALL have input pulse, 1 bit, one-cycle tick from flash timer.
REQ-007 SHALL have input empty, 1 bit, 1 = no player entry pending from checker.
REQ-008 SHALL have input result, 1 bit, 1 = pending entry matches segment[check_round]; valid only when empty=0.
REQ-009 SHALL have outputs rst_seedgen, start, load_colour, load_speed, pop, each 1 bit, one-cycle strobes.
REQ-010 SHALL have outputs flash_colour, player_turn, game_over, win, each 1 bit, state levels.
REQ-011 SHALL have outputs check_round 5 bits (segment index) and speed 3 bits (timer rate code 0..4).

Function
REQ-012 SHALL implement states IDLE, SEED, ADD, SPEED, FLASH, PLAY, WIN, LOSE; internal round register r (5 bits), index idx (5 bits), timeout counter (4 bits).
REQ-013 IDLE: all outputs 0; go=1 -> SEED.
REQ-014 SEED: rst_seedgen=1 one cycle; r<=0; -> ADD.
REQ-015 ADD: start=1 and load_colour=1 one cycle; -> SPEED.
REQ-016 SPEED: speed<=min(r/ROUNDS_PER_SPEEDUP, 4); load_speed=1 one cycle; idx<=0; -> FLASH.
REQ-017 FLASH: flash_colour=1; check_round=idx; on pulse: idx==r -> PLAY with idx<=0, timeout<=0; else idx<=idx+1.
REQ-018 PLAY: player_turn=1; check_round=idx; when empty=0: pop=1 same cycle, result evaluated same cycle.
REQ-019 PLAY entry: result=0 -> LOSE; result=1, idx<r -> idx<=idx+1, timeout<=0; result=1, idx==r, r==MAX_ROUND -> WIN; else r<=r+1 -> ADD.
REQ-020 PLAY timeout: pulse with empty=1 increments timeout; reaching TIMEOUT_PULSES -> LOSE.
REQ-021 PLAY: entry (empty=0) and pulse in same cycle -> entry processed, timeout not incremented.
REQ-022 WIN: win=1; LOSE: game_over=1; check_round holds last idx; go=1 -> SEED (full restart).
REQ-023 go SHALL be ignored in SEED, ADD, SPEED, FLASH, PLAY.
REQ-024 pulse SHALL be ignored outside FLASH and PLAY; empty/result ignored outside PLAY (pop=0).
REQ-025 check_round SHALL be 0 in IDLE..SPEED; speed holds value between SPEED states.
REQ-026 r SHALL never exceed MAX_ROUND; no wrap of r or idx.

Reset
REQ-027 reset=1 SHALL, at next clk edge, force IDLE, r=0, idx=0, timeout=0, speed=0, all strobes and levels 0, regardless of state.
REQ-028 reset SHALL take priority over go, pulse and empty in the same cycle.

Structure
REQ-029 State enum, speed codes (0=1Hz..4=16Hz) and parameter defaults SHALL live in shared package simon_pkg.
REQ-030 Speed mapping SHALL be a package function; no sub-module, single registered-state FSM with combinational strobe decode.
REQ-031 Port names SHALL match the fsm modport of fsm_sig, plus go, pop, game_over, win.

Verification
REQ-032 Reset then go=1 one cycle -> rst_seedgen cycle 1, start+load_colour cycle 2, load_speed cycle 3 with speed=0, flash_colour from cycle 4.
REQ-033 Round r=2 in FLASH, 3 pulses -> check_round 0,1,2 then player_turn=1, check_round=0.
REQ-034 PLAY r=2, three entries result=1 -> pop each, r=3, ADD strobe; at r=4 SPEED gives speed=1; r=16..31 gives speed=4.
REQ-035 PLAY, entry with result=0 at idx=1 -> pop=1, next cycle game_over=1; go -> SEED, r=0.
REQ-036 PLAY, 8 pulses with empty=1 -> LOSE; entry coincident with 8th pulse -> entry wins, no LOSE.
REQ-037 MAX_ROUND=3, all correct -> win=1 after r=3 completes; reset mid-FLASH -> IDLE, all outputs 0 next cycle.
